// File: rtl/faerie_cu_wide.sv
// Faerie CPU control unit: sequences fetch/address/pointer/operand/ALU/store/branch/IRQ.
// Latency: strobes are combinational from the current state; one state per cycle.
// Backpressure: mem_ready=0 freezes every memory state and suppresses all capture strobes.
module faerie_cu_wide #(
    parameter int ADDR_BYTES = 2,
    parameter bit IRQ_EN     = 1'b1,
    localparam int IW        = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rdata,
    input  logic                  mem_ready,
    input  logic                  irq,
    output logic                  re,
    output logic                  we,
    output logic                  pc_addr,
    output logic                  pc_inc,
    output logic                  zp_addr,
    output logic [ADDR_BYTES-1:0] set_ab,
    output logic [IW-1:0]         ptr_off,
    output logic                  set_b,
    output logic                  reset_b,
    output logic                  set_fr,
    output logic                  set_a,
    output logic                  branch,
    output logic                  irq_ack,
    output logic                  vec_load,
    output logic [2:0]            state_o,
    output logic [7:0]            ir_o
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_ADDR  = 3'd1,
        S_PTR   = 3'd2,
        S_OPR   = 3'd3,
        S_ALU   = 3'd4,
        S_ST    = 3'd5,
        S_BR    = 3'd6,
        S_IRQ   = 3'd7
    } state_t;

    // Addressing modes (insn[3:2]) and instruction classes (insn[1:0]).
    localparam logic [1:0] AM_ZP  = 2'b00;
    localparam logic [1:0] AM_PTR = 2'b01;
    localparam logic [1:0] AM_ABS = 2'b10;
    localparam logic [1:0] AM_IMM = 2'b11;

    localparam logic [1:0] CL_ST  = 2'b10;
    localparam logic [1:0] CL_BR  = 2'b11;

    localparam logic [IW-1:0]         LAST_IDX = IW'(ADDR_BYTES - 1);
    localparam logic [ADDR_BYTES-1:0] AB_ONE   = ADDR_BYTES'(1);

    state_t      state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]  ir_q, ir_d;

    logic [1:0]  amode, cls;
    logic [1:0]  f_amode, f_cls;
    logic        last_idx;
    logic [IW-1:0] hi_idx;
    state_t      exec_state;
    state_t      boundary_state;

    assign amode    = ir_q[3:2];
    assign cls      = ir_q[1:0];
    // In FETCH the decision is made on the byte arriving now, before IR holds it.
    assign f_amode  = rdata[3:2];
    assign f_cls    = rdata[1:0];
    assign last_idx = (idx_q == LAST_IDX);
    // Pointer bytes are read high to low so AR byte 0 (the pointer itself) is replaced last.
    assign hi_idx   = LAST_IDX - idx_q;

    // Where an instruction goes once its effective address is known.
    always_comb begin
        unique case (cls)
            CL_ST:   exec_state = S_ST;
            CL_BR:   exec_state = S_BR;
            default: exec_state = S_OPR;
        endcase
    end

    // Instruction boundary: the only point an interrupt may be taken.
    assign boundary_state = (IRQ_EN && irq) ? S_IRQ : S_FETCH;

    // State, byte index and instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            idx_q   <= '0;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and control strobes; all strobes forced low while reset is asserted.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ir_d     = ir_q;
        re       = 1'b0;
        we       = 1'b0;
        pc_addr  = 1'b0;
        pc_inc   = 1'b0;
        zp_addr  = 1'b0;
        set_ab   = '0;
        ptr_off  = '0;
        set_b    = 1'b0;
        reset_b  = 1'b0;
        set_fr   = 1'b0;
        set_a    = 1'b0;
        branch   = 1'b0;
        irq_ack  = 1'b0;
        vec_load = 1'b0;

        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    re      = 1'b1;
                    pc_addr = 1'b1;
                    reset_b = 1'b1;
                    if (mem_ready) begin
                        ir_d   = rdata;
                        pc_inc = 1'b1;
                        idx_d  = '0;
                        if (f_amode == AM_IMM) begin
                            // Immediate store/branch has no target: it retires as a NOP.
                            state_d = (f_cls[1] == 1'b0) ? S_OPR : boundary_state;
                        end else begin
                            state_d = S_ADDR;
                        end
                    end
                end

                S_ADDR: begin
                    re      = 1'b1;
                    pc_addr = 1'b1;
                    if (mem_ready) begin
                        pc_inc = 1'b1;
                        set_ab = AB_ONE << idx_q;
                        if (amode != AM_ABS || last_idx) begin
                            idx_d   = '0;
                            state_d = (amode == AM_PTR) ? S_PTR : exec_state;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end

                S_PTR: begin
                    re      = 1'b1;
                    zp_addr = 1'b1;
                    ptr_off = hi_idx;
                    if (mem_ready) begin
                        set_ab = AB_ONE << hi_idx;
                        if (last_idx) begin
                            idx_d   = '0;
                            state_d = exec_state;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end

                S_OPR: begin
                    re      = 1'b1;
                    pc_addr = (amode == AM_IMM);
                    zp_addr = (amode == AM_ZP);
                    if (mem_ready) begin
                        set_b   = 1'b1;
                        pc_inc  = (amode == AM_IMM);
                        state_d = S_ALU;
                    end
                end

                S_ALU: begin
                    set_fr  = 1'b1;
                    set_a   = ~ir_q[0];
                    state_d = boundary_state;
                end

                S_ST: begin
                    we      = 1'b1;
                    zp_addr = (amode == AM_ZP);
                    if (mem_ready) begin
                        state_d = boundary_state;
                    end
                end

                S_BR: begin
                    branch  = 1'b1;
                    zp_addr = (amode == AM_ZP);
                    state_d = boundary_state;
                end

                S_IRQ: begin
                    irq_ack  = IRQ_EN;
                    vec_load = IRQ_EN;
                    state_d  = S_FETCH;
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign ir_o    = ir_q;

endmodule

// File: doc/faerie_cu_wide.md
Name: faerie_cu_wide

Overview:
- Next-generation control unit for the Faerie 8-bit CPU.
- Sequences instruction fetch, operand-address fetch, zero-page pointer indirection, operand read, ALU, store and branch, and drives one-cycle control strobes to the datapath.
- Generalised over address width (ADDR_BYTES bytes of AR).
- Adds a memory wait-state handshake and an instruction-boundary interrupt entry.

Parameters:
- ADDR_BYTES, 2, number of AR bytes / absolute-address operand bytes; legal 1..4.
- IRQ_EN, 1, when 0 the irq input is ignored and irq_ack/vec_load are tied 0.
- IW, derived max(1,$clog2(ADDR_BYTES)), width of the byte index.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  Reset. Asynchronous assert, active-high.
- rdata  in  8  Memory read data, valid in any cycle where mem_ready=1.
- mem_ready  in  1  Memory access completes this cycle.
- irq  in  1  Level-sensitive interrupt request.
- re  out  1  Memory read enable.
- we  out  1  Memory write enable (stores A).
- pc_addr  out  1  Use PC as address, else AR.
- pc_inc  out  1  Increment PC.
- zp_addr  out  1  Force AR high bytes to zero (zero-page addressing).
- set_ab  out  ADDR_BYTES  One-hot write enable of AR byte i from rdata.
- ptr_off  out  IW  Zero-page offset added to AR byte 0 during pointer reads.
- set_b  out  1  Latch rdata into B.
- reset_b  out  1  Clear B.
- set_fr  out  1  Write ALU flags.
- set_a  out  1  Write ALU result to A.
- branch  out  1  Load PC from AR if the branch condition holds.
- irq_ack  out  1  Interrupt taken.
- vec_load  out  1  Load PC with the interrupt vector.
- state_o  out  3  Current state encoding, for debug.
- ir_o  out  8  Instruction register.

Behaviour:

Instruction decode:
- insn[3:2] amode: 00 zero-page, 01 zp pointer, 10 absolute, 11 immediate.
- insn[1:0] class: 00 ALU with writeback, 01 ALU flags-only (compare), 10 store, 11 branch.
- insn[7:4] are ignored by this block.

States, with state_o encoding:
- FETCH=0, ADDR=1, PTR=2, OPR=3, ALU=4, ST=5, BR=6, IRQ=7.
- Byte counter idx (IW bits).
- Any output not listed for a state is 0.

Per-state outputs and transitions:
- FETCH: re, pc_addr, reset_b.
  - If mem_ready: IR<=rdata, pc_inc=1.
  - Next state uses the new rdata decode: amode 11 with ALU class → OPR; amode 11 with store/branch class → NOP, go to boundary; otherwise → ADDR with idx=0.
- ADDR: re, pc_addr, set_ab[idx], with pc_inc on ready.
  - zero-page and pointer modes read 1 byte (byte 0).
  - absolute mode reads bytes 0..ADDR_BYTES-1, idx incrementing on each ready.
  - Last byte: pointer mode → PTR with idx=0; otherwise → exec.
- PTR: re, zp_addr, ptr_off=ADDR_BYTES-1-idx, set_ab[ADDR_BYTES-1-idx].
  - Bytes are fetched high to low; AR byte 0 is overwritten last.
  - After idx=ADDR_BYTES-1 with ready → exec.
- exec dispatch: ALU class → OPR; store → ST; branch → BR.
- OPR: re, set_b.
  - immediate mode: pc_addr=1, pc_inc on ready.
  - zero-page mode: zp_addr=1.
  - On ready → ALU.
- ALU: set_fr=1, set_a=!insn[0]. One cycle, then boundary.
- ST: we, zp_addr if amode 00. Held until ready, then boundary.
- BR: branch=1, zp_addr if amode 00. One cycle, then boundary.
- boundary: (IRQ_EN && irq) ? IRQ : FETCH.
- IRQ: irq_ack=1, vec_load=1. One cycle → FETCH; irq is not re-sampled here.

Stall rule:
- In FETCH/ADDR/PTR/OPR/ST with mem_ready=0: state, idx and IR hold, outputs are repeated unchanged, and pc_inc/set_ab/set_b/IR capture are suppressed.
- Writes to AR/B/IR happen only on a ready cycle.

Reset and interrupt timing:
- Reset (async): state=FETCH, idx=0, IR=0x00.
- While rst=1, all outputs are 0.
- The first cycle after release is FETCH. An interrupt is never taken before the first instruction completes.
- irq asserting mid-instruction has no effect until that instruction's boundary.

Latency with zero wait states, N=ADDR_BYTES:
- imm ALU: 3 cycles.
- zp ALU: 4 cycles.
- abs ALU: 3+N cycles.
- ptr ALU: 4+N cycles.
- abs store/branch: 2+N cycles.
- imm store/branch NOP: 1 cycle.

Test Plan:
- ADDR_BYTES=2, mem_ready=1, insn 0x08 (abs ALU) → states 0,1,1,3,4. set_ab=01 then 10. pc_inc asserted 3 times. set_a=1 in the ALU cycle.
- insn 0x04 (ptr ALU), N=2 → 0,1,2,2,3,4. In PTR: ptr_off=1 with set_ab=10, then ptr_off=0 with set_ab=01. zp_addr=1 in both PTR cycles.
- insn 0x0D (imm compare) → 0,3,4. pc_addr=1 in OPR. set_fr=1, set_a=0. insn 0x0E → single FETCH cycle, then FETCH again.
- insn 0x0A (abs store) with mem_ready low for 3 cycles in ST → we held 4 cycles. No boundary transition until ready. No spurious pc_inc.
- irq=1 during the ADDR cycle of insn 0x0B → BR completes with branch=1, then one IRQ cycle with irq_ack=vec_load=1, then FETCH.
- rst pulsed mid-PTR → all outputs 0 immediately. After release: FETCH, ir_o=0x00. With irq held high through reset, the first instruction still executes before IRQ is taken.
